// File: rtl/acc_flag_writeback_if.sv
// Handshake bundle between the ALU and the writeback stage, and between the
// writeback stage and the register-file write port.
// slave  : the writeback stage.
// master : the ALU / register-file side that drives and observes the stage.
interface acc_flag_writeback_if #(
  parameter int W     = 8,
  parameter int RF_AW = 4
);
  // ALU result side
  logic             in_valid;
  logic             in_ready;
  logic             optype;
  logic [3:0]       op;
  logic [W-1:0]     result;
  logic             c_in;
  logic             z_in;
  logic             n_in;
  logic             a_msb;
  logic             b_msb;
  logic             dst_rf;
  logic [RF_AW-1:0] rf_addr;
  // Register-file write side
  logic             rf_we;
  logic [RF_AW-1:0] rf_waddr;
  logic [W-1:0]     rf_wdata;
  logic             rf_ack;

  modport slave (
    input  in_valid, optype, op, result, c_in, z_in, n_in, a_msb, b_msb,
           dst_rf, rf_addr, rf_ack,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output in_valid, optype, op, result, c_in, z_in, n_in, a_msb, b_msb,
           dst_rf, rf_addr, rf_ack,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/acc_flag_writeback.sv
// Writeback stage behind the 8-bit accumulator ALU: updates the accumulator
// and Z/C/N/V flags per opcode, forwards register-file writes through an ack
// handshake, and evaluates branch conditions from the registered flags.
// Optional feature macro: ACC_BYPASS_EN (same-cycle accumulator forwarding).
module acc_flag_writeback #(
  parameter int W        = 8,
  parameter int RF_AW    = 4,
  parameter int STALL_CW = 8
) (
  input  logic                clk,
  input  logic                reset,
  acc_flag_writeback_if.slave bus,
  output logic [W-1:0]        acc,
  output logic [W-1:0]        acc_fwd,
  output logic                z,
  output logic                c,
  output logic                n,
  output logic                v,
  input  logic [2:0]          cond,
  output logic                cond_true,
  output logic [STALL_CW-1:0] stall_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    RF_WAIT = 1'b1
  } state_t;

  state_t state;

  logic accept;
  logic is_add;
  logic is_sub;
  logic is_logic;
  logic is_cmp;
  logic writes;
  logic res_zero;
  logic res_msb;

  // Opcode decode and accept qualification
  always_comb begin
    is_add   = 1'b0;
    is_sub   = 1'b0;
    is_logic = 1'b0;
    is_cmp   = 1'b0;
    if (!bus.optype) begin
      case (bus.op)
        4'b0010: is_add   = 1'b1;
        4'b0011: is_sub   = 1'b1;
        4'b0100, 4'b0101, 4'b0110,
        4'b0111, 4'b1000, 4'b1001: is_logic = 1'b1;
        4'b1010: is_cmp   = 1'b1;
        default: ;
      endcase
    end
    writes       = bus.optype | is_add | is_sub | is_logic;
    bus.in_ready = (state == IDLE);
    accept       = bus.in_valid && (state == IDLE);
    res_zero     = (bus.result == '0);
    res_msb      = bus.result[W-1];
  end

  // Accumulator, flags, RF write port and wait-state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      acc          <= '0;
      z            <= 1'b0;
      c            <= 1'b0;
      n            <= 1'b0;
      v            <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      stall_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_add || is_sub || is_logic) begin
              z <= res_zero;
              n <= res_msb;
            end
            if (is_add) begin
              c <= bus.c_in;
              v <= (bus.a_msb == bus.b_msb) && (res_msb != bus.a_msb);
            end
            if (is_sub) begin
              c <= bus.c_in;
              v <= (bus.a_msb != bus.b_msb) && (res_msb != bus.a_msb);
            end
            if (is_cmp) begin
              z <= bus.z_in;
              n <= bus.n_in;
            end
            if (writes) begin
              if (!bus.dst_rf) begin
                acc <= bus.result;
              end else begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= bus.rf_addr;
                bus.rf_wdata <= bus.result;
                state        <= RF_WAIT;
              end
            end
          end
        end
        RF_WAIT: begin
          if (bus.rf_ack) begin
            bus.rf_we <= 1'b0;
            state     <= IDLE;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulator operand path toward the ALU
  always_comb begin
    acc_fwd = acc;
`ifdef ACC_BYPASS_EN
    if (accept && writes && !bus.dst_rf) acc_fwd = bus.result;
`endif
  end

  // Branch condition select from registered flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = z;
      3'b010: cond_true = !z;
      3'b011: cond_true = c;
      3'b100: cond_true = !c;
      3'b101: cond_true = n;
      3'b110: cond_true = !n;
      3'b111: cond_true = v;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_acc_flag_writeback.sv
// Directed self-checking bench for acc_flag_writeback (both macro builds).
module tb_acc_flag_writeback;

  localparam int W        = 8;
  localparam int RF_AW    = 4;
  localparam int STALL_CW = 8;

  logic                clk;
  logic                reset;
  logic [W-1:0]        acc;
  logic [W-1:0]        acc_fwd;
  logic                z, c, n, v;
  logic [2:0]          cond;
  logic                cond_true;
  logic [STALL_CW-1:0] stall_cnt;

  int unsigned n_checks;
  int unsigned n_fail;

  acc_flag_writeback_if #(.W(W), .RF_AW(RF_AW)) bus ();

  acc_flag_writeback #(
    .W(W), .RF_AW(RF_AW), .STALL_CW(STALL_CW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .acc(acc), .acc_fwd(acc_fwd),
    .z(z), .c(c), .n(n), .v(v),
    .cond(cond), .cond_true(cond_true), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ot, input logic [3:0] o, input logic [W-1:0] r,
                       input logic ci, input logic zi, input logic ni,
                       input logic am, input logic bm, input logic d,
                       input logic [RF_AW-1:0] ad);
    bus.in_valid = 1'b1;
    bus.optype   = ot;
    bus.op       = o;
    bus.result   = r;
    bus.c_in     = ci;
    bus.z_in     = zi;
    bus.n_in     = ni;
    bus.a_msb    = am;
    bus.b_msb    = bm;
    bus.dst_rf   = d;
    bus.rf_addr  = ad;
  endtask

  task automatic flags(input string tag, input logic ez, input logic ec,
                       input logic en, input logic ev);
    chk({tag, ".z"}, {31'd0, z}, {31'd0, ez});
    chk({tag, ".c"}, {31'd0, c}, {31'd0, ec});
    chk({tag, ".n"}, {31'd0, n}, {31'd0, en});
    chk({tag, ".v"}, {31'd0, v}, {31'd0, ev});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    cond  = 3'b000;
    bus.in_valid = 1'b0; bus.optype = 1'b0; bus.op = 4'h0; bus.result = '0;
    bus.c_in = 1'b0; bus.z_in = 1'b0; bus.n_in = 1'b0; bus.a_msb = 1'b0;
    bus.b_msb = 1'b0; bus.dst_rf = 1'b0; bus.rf_addr = '0; bus.rf_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst.acc", {24'd0, acc}, 32'h00);
    flags("rst", 0, 0, 0, 0);
    chk("rst.rf_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rst.rf_waddr", {28'd0, bus.rf_waddr}, 32'd0);
    chk("rst.rf_wdata", {24'd0, bus.rf_wdata}, 32'd0);
    chk("rst.stall", {24'd0, stall_cnt}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // add 0x80, positive operands -> signed overflow
    drive(0, 4'b0010, 8'h80, 0, 0, 0, 0, 0, 0, 4'h0);
    #1;
`ifdef ACC_BYPASS_EN
    chk("add.acc_fwd_same", {24'd0, acc_fwd}, 32'h80);
`else
    chk("add.acc_fwd_same", {24'd0, acc_fwd}, 32'h00);
`endif
    tick();
    bus.in_valid = 1'b0;
    chk("add.acc", {24'd0, acc}, 32'h80);
    flags("add", 0, 0, 1, 1);
    cond = 3'b111; #1; chk("add.cond111", {31'd0, cond_true}, 32'd1);
    cond = 3'b000; #1; chk("add.cond000", {31'd0, cond_true}, 32'd1);
    cond = 3'b001; #1; chk("add.cond001", {31'd0, cond_true}, 32'd0);

    // sub -> 0 with carry, equal-sign operands -> no overflow
    drive(0, 4'b0011, 8'h00, 1, 0, 0, 1, 1, 0, 4'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("sub.acc", {24'd0, acc}, 32'h00);
    flags("sub", 1, 1, 0, 0);
    cond = 3'b001; #1; chk("sub.cond001", {31'd0, cond_true}, 32'd1);
    cond = 3'b011; #1; chk("sub.cond011", {31'd0, cond_true}, 32'd1);
    cond = 3'b100; #1; chk("sub.cond100", {31'd0, cond_true}, 32'd0);

    // xor 0x01: z/n updated, carry retained
    drive(0, 4'b1000, 8'h01, 0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("xor.acc", {24'd0, acc}, 32'h01);
    flags("xor", 0, 1, 0, 0);
    cond = 3'b010; #1; chk("xor.cond010", {31'd0, cond_true}, 32'd1);

    // cmp: flags from z_in/n_in, no data write
    drive(0, 4'b1010, 8'h55, 1, 0, 1, 0, 0, 0, 4'h0);
    #1; chk("cmp.acc_fwd_same", {24'd0, acc_fwd}, 32'h01);
    tick();
    bus.in_valid = 1'b0;
    chk("cmp.acc", {24'd0, acc}, 32'h01);
    flags("cmp", 0, 1, 1, 0);
    cond = 3'b101; #1; chk("cmp.cond101", {31'd0, cond_true}, 32'd1);
    cond = 3'b110; #1; chk("cmp.cond110", {31'd0, cond_true}, 32'd0);

    // op 1111 and op 0000: accepted and dropped
    drive(0, 4'b1111, 8'h00, 0, 1, 0, 1, 0, 0, 4'h0);
    tick();
    drive(0, 4'b0000, 8'h33, 0, 1, 0, 1, 0, 0, 4'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("nop.acc", {24'd0, acc}, 32'h01);
    flags("nop", 0, 1, 1, 0);
    chk("nop.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // shl -> 0: z set, c kept
    drive(0, 4'b0100, 8'h00, 0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    // back-to-back add then sub
    drive(0, 4'b0010, 8'h7F, 1, 0, 0, 0, 0, 0, 4'h0);
    chk("shl.acc", {24'd0, acc}, 32'h00);
    flags("shl", 1, 1, 0, 0);
    tick();
    chk("b2b1.acc", {24'd0, acc}, 32'h7F);
    flags("b2b1", 0, 1, 0, 0);
    drive(0, 4'b0011, 8'hFF, 0, 0, 0, 0, 1, 0, 4'h0);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b2.acc", {24'd0, acc}, 32'hFF);
    flags("b2b2", 0, 0, 1, 1);

    // RF write with 3 wait cycles; a held in_valid must not be taken
    drive(1, 4'h0, 8'h2A, 0, 0, 0, 0, 0, 1, 4'h3);
    tick();
    drive(1, 4'h0, 8'h99, 0, 0, 0, 0, 0, 0, 4'h9);
    for (int unsigned i = 0; i < 4; i++) begin
      chk($sformatf("rf.we%0d", i), {31'd0, bus.rf_we}, 32'd1);
      chk($sformatf("rf.addr%0d", i), {28'd0, bus.rf_waddr}, 32'h3);
      chk($sformatf("rf.data%0d", i), {24'd0, bus.rf_wdata}, 32'h2A);
      chk($sformatf("rf.rdy%0d", i), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("rf.stall%0d", i), {24'd0, stall_cnt}, i);
      if (i == 3) begin
        bus.rf_ack   = 1'b1;
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.rf_ack = 1'b0;
    chk("rf.done_we", {31'd0, bus.rf_we}, 32'd0);
    chk("rf.done_rdy", {31'd0, bus.in_ready}, 32'd1);
    chk("rf.done_stall", {24'd0, stall_cnt}, 32'd3);
    chk("rf.acc_kept", {24'd0, acc}, 32'hFF);
    flags("rf", 0, 0, 1, 1);

    // Stray ack in IDLE is ignored
    bus.rf_ack = 1'b1;
    tick();
    bus.rf_ack = 1'b0;
    chk("ack_idle.we", {31'd0, bus.rf_we}, 32'd0);
    chk("ack_idle.stall", {24'd0, stall_cnt}, 32'd3);

    // Stall counter saturation
    drive(1, 4'h0, 8'h11, 0, 0, 0, 0, 0, 1, 4'h7);
    tick();
    bus.in_valid = 1'b0;
    for (int unsigned i = 0; i < 300; i++) tick();
    chk("sat.stall", {24'd0, stall_cnt}, 32'hFF);
    chk("sat.we", {31'd0, bus.rf_we}, 32'd1);

    // Reset during RF_WAIT abandons the write
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstw.we", {31'd0, bus.rf_we}, 32'd0);
    chk("rstw.acc", {24'd0, acc}, 32'h00);
    flags("rstw", 0, 0, 0, 0);
    chk("rstw.stall", {24'd0, stall_cnt}, 32'd0);
    chk("rstw.rdy", {31'd0, bus.in_ready}, 32'd1);
    tick(); tick(); tick();
    chk("rstw.no_reissue", {31'd0, bus.rf_we}, 32'd0);

    // Move/immediate into accumulator, bypass visibility
    drive(1, 4'h0, 8'h7E, 0, 0, 0, 0, 0, 0, 4'h0);
    #1;
`ifdef ACC_BYPASS_EN
    chk("mov.acc_fwd_same", {24'd0, acc_fwd}, 32'h7E);
`else
    chk("mov.acc_fwd_same", {24'd0, acc_fwd}, 32'h00);
`endif
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("mov.acc", {24'd0, acc}, 32'h7E);
    chk("mov.acc_fwd_next", {24'd0, acc_fwd}, 32'h7E);
    flags("mov", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
